// File: rtl/studio2_pkg.sv
// Shared types and address-map constants for the Studio II memory arbiter.
package studio2_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic [1:0] {SRC_RAM, SRC_ROM, SRC_FF} src_t;
  typedef enum logic [1:0] {RQ_NONE, RQ_CPU, RQ_DMA, RQ_LD} req_t;
  typedef enum logic [2:0] {RGN_ROM, RGN_CART, RGN_RAM, RGN_MCART, RGN_MIRROR} region_t;

  localparam logic [11:0] ROM_BASE      = 12'h000;
  localparam logic [11:0] CART_BASE     = 12'h400;
  localparam logic [11:0] RAM_BASE      = 12'h800;
  localparam logic [11:0] MCART_LO_BASE = 12'hA00;
  localparam logic [11:0] MIRROR_BASE   = 12'hC00;
  localparam logic [11:0] MCART_HI_BASE = 12'hE00;

endpackage

// File: rtl/studio2_mem_arbiter_if.sv
// Requester, RAM and ROM signal bundle; the arbiter takes the slave side.
interface studio2_mem_arbiter_if #(parameter int ROM_AW = 11);
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              dma_req;
  logic [15:0]       dma_addr;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [7:0]        dma_rdata;
  logic              ld_req;
  logic [15:0]       ld_addr;
  logic [7:0]        ld_wdata;
  logic              ld_gnt;
  logic              cart_present;
  logic              mem_ce;
  logic              mem_we;
  logic [11:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_rdata;
  logic              prot_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr,
           ld_req, ld_addr, ld_wdata, cart_present, mem_rdata, rom_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
           ld_gnt, mem_ce, mem_we, mem_addr, mem_wdata, rom_addr, prot_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_addr,
           ld_req, ld_addr, ld_wdata, cart_present, mem_rdata, rom_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
           ld_gnt, mem_ce, mem_we, mem_addr, mem_wdata, rom_addr, prot_err
  );
endinterface

// File: rtl/studio2_addr_decode.sv
// CDP1802 address map: 12-bit address -> region, read source, write permit, physical addresses.
// Purely combinational; STUDIO2_RAM_MIRROR_EN maps 0xC00-0xDFF onto 0x800-0x9FF.
module studio2_addr_decode
  import studio2_pkg::*;
#(
  parameter int ROM_AW = 11
) (
  input  logic [11:0]       addr,
  input  logic              cart_present,
  input  req_t              requester,
  output region_t           region,
  output src_t              src,
  output logic              wr_ok,
  output logic [11:0]       ram_addr,
  output logic [ROM_AW-1:0] rom_addr
);

  logic is_ld;
  assign is_ld    = (requester == RQ_LD);
  assign rom_addr = addr[ROM_AW-1:0];

  always_comb begin
    if (addr >= MCART_HI_BASE)      region = RGN_MCART;
    else if (addr >= MIRROR_BASE)   region = RGN_MIRROR;
    else if (addr >= MCART_LO_BASE) region = RGN_MCART;
    else if (addr >= RAM_BASE)      region = RGN_RAM;
    else if (addr >= CART_BASE)     region = RGN_CART;
    else                            region = RGN_ROM;
  end

  always_comb begin
    src      = SRC_FF;
    wr_ok    = 1'b0;
    ram_addr = addr;
    case (region)
      RGN_ROM: begin
        src   = SRC_ROM;
        wr_ok = 1'b0;
      end
      RGN_CART: begin
        src   = cart_present ? SRC_RAM : SRC_ROM;
        wr_ok = is_ld;
      end
      RGN_RAM: begin
        src   = SRC_RAM;
        wr_ok = 1'b1;
      end
      RGN_MCART: begin
        src   = SRC_RAM;
        wr_ok = is_ld;
      end
      RGN_MIRROR: begin
`ifdef STUDIO2_RAM_MIRROR_EN
        src      = SRC_RAM;
        wr_ok    = 1'b1;
        ram_addr = {3'b100, addr[8:0]};
`else
        src   = SRC_FF;
        wr_ok = 1'b0;
`endif
      end
      default: begin
        src   = SRC_FF;
        wr_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Arbitrates RAM/ROM among Pixie DMA, CPU and loader; one grant per cycle, read data at N+1.
// Ungranted requesters must hold their request. Optional macro: STUDIO2_RAM_MIRROR_EN.
module studio2_mem_arbiter #(
  parameter int CPU_MAX_WAIT = 3,
  parameter int ROM_AW       = 11
) (
  input logic                  clk,
  input logic                  reset,
  studio2_mem_arbiter_if.slave bus
);
  import studio2_pkg::*;

  localparam int WW = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);

  logic [WW-1:0]     wait_cnt;
  logic              boost;
  logic              dma_g, ld_g, cpu_g;
  req_t              sel;
  logic [11:0]       g_addr;
  logic              g_we;
  logic [7:0]        g_wdata;
  region_t           region;
  src_t              src;
  logic              wr_ok;
  logic [11:0]       ram_addr;
  logic [ROM_AW-1:0] rom_addr;
  owner_t            owner_q;
  src_t              src_q;
  logic [7:0]        rd_mux;
  logic              unused_bits;

  assign boost = (wait_cnt == WW'(CPU_MAX_WAIT));

  // DMA always wins: video fetch timing cannot slip.
  always_comb begin
    dma_g = 1'b0;
    ld_g  = 1'b0;
    cpu_g = 1'b0;
    if (!reset) begin
      if (bus.dma_req)                dma_g = 1'b1;
      else if (boost && bus.cpu_req)  cpu_g = 1'b1;
      else if (bus.ld_req)            ld_g  = 1'b1;
      else if (bus.cpu_req)           cpu_g = 1'b1;
    end
  end

  always_comb begin
    sel     = RQ_NONE;
    g_addr  = 12'h000;
    g_we    = 1'b0;
    g_wdata = 8'h00;
    if (dma_g) begin
      sel    = RQ_DMA;
      g_addr = bus.dma_addr[11:0];
    end else if (ld_g) begin
      sel     = RQ_LD;
      g_addr  = bus.ld_addr[11:0];
      g_we    = 1'b1;
      g_wdata = bus.ld_wdata;
    end else if (cpu_g) begin
      sel     = RQ_CPU;
      g_addr  = bus.cpu_addr[11:0];
      g_we    = bus.cpu_we;
      g_wdata = bus.cpu_wdata;
    end
  end

  studio2_addr_decode #(.ROM_AW(ROM_AW)) u_decode (
    .addr         (g_addr),
    .cart_present (bus.cart_present),
    .requester    (sel),
    .region       (region),
    .src          (src),
    .wr_ok        (wr_ok),
    .ram_addr     (ram_addr),
    .rom_addr     (rom_addr)
  );

  assign bus.dma_gnt   = dma_g;
  assign bus.ld_gnt    = ld_g;
  assign bus.cpu_gnt   = cpu_g;
  assign bus.mem_ce    = (sel != RQ_NONE) && (g_we ? wr_ok : (src == SRC_RAM));
  assign bus.mem_we    = g_we && wr_ok;
  assign bus.mem_addr  = ram_addr;
  assign bus.mem_wdata = g_wdata;
  assign bus.rom_addr  = rom_addr;
  // A dropped write still uses its grant slot.
  assign bus.prot_err  = g_we && !wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      owner_q  <= OWN_NONE;
      src_q    <= SRC_FF;
    end else begin
      if (!bus.cpu_req || cpu_g)
        wait_cnt <= '0;
      else if (ld_g && !boost)
        wait_cnt <= wait_cnt + WW'(1);

      if (sel == RQ_DMA)
        owner_q <= OWN_DMA;
      else if (sel == RQ_CPU && !g_we)
        owner_q <= OWN_CPU;
      else
        owner_q <= OWN_NONE;
      src_q <= src;
    end
  end

  always_comb begin
    rd_mux = 8'hFF;
    case (src_q)
      SRC_RAM: rd_mux = bus.mem_rdata;
      SRC_ROM: rd_mux = bus.rom_rdata;
      default: rd_mux = 8'hFF;
    endcase
  end

  assign bus.cpu_rvalid = (owner_q == OWN_CPU);
  assign bus.dma_rvalid = (owner_q == OWN_DMA);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? rd_mux : 8'h00;
  assign bus.dma_rdata  = bus.dma_rvalid ? rd_mux : 8'h00;

  assign unused_bits = ^{bus.cpu_addr[15:12], bus.dma_addr[15:12], bus.ld_addr[15:12], region};

endmodule

// File: doc/studio2_mem_arbiter.md
# studio2_mem_arbiter

Shared-memory controller for the Studio II core. It arbitrates the single-port 4 KB system RAM and the 2 KB system ROM among three requesters: Pixie video DMA, the CPU bus, and the ioctl loader. It decodes the CDP1802 address map and enforces write protection on ROM and cartridge space. It returns read data to each requester with a fixed one-cycle latency. It sits between `cdp1802`/`pixie_dp`/ioctl and the `dpram`/`rom` instances.

## Interface
Parameters:
- `CPU_MAX_WAIT`, default 3. Consecutive cycles the CPU may be denied by the loader before CPU priority is boosted above the loader.
- `ROM_AW`, default 11. System ROM address width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1 / `cpu_we` in 1 / `cpu_addr` in 16 / `cpu_wdata` in 8: CPU access request.
- `cpu_gnt` out 1: CPU access accepted this cycle.
- `cpu_rvalid` out 1 / `cpu_rdata` out 8: CPU read return.
- `dma_req` in 1 / `dma_addr` in 16: Pixie DMA read request.
- `dma_gnt` out 1: DMA access accepted this cycle.
- `dma_rvalid` out 1 / `dma_rdata` out 8: DMA read return.
- `ld_req` in 1 / `ld_addr` in 16 / `ld_wdata` in 8: loader write request. The loader is write-only.
- `ld_gnt` out 1: loader write accepted this cycle.
- `cart_present` in 1: when 1, 0x400–0x7FF is served from RAM (cartridge); when 0, it is served from ROM (built-in games).
- `mem_ce` out 1 / `mem_we` out 1 / `mem_addr` out 12 / `mem_wdata` out 8 / `mem_rdata` in 8: synchronous RAM port.
- `rom_addr` out `ROM_AW` / `rom_rdata` in 8: synchronous ROM port.
- `prot_err` out 1: one-cycle pulse when a write targets a protected region.

## Operation
Address decode uses `addr[11:0]`. Addresses with `addr[15:12]` != 0 alias down to 12 bits.
- 0x000–0x3FF: ROM. Reads come from ROM; writes are dropped.
- 0x400–0x7FF: cartridge region.
  - `cart_present=1`: reads come from RAM.
  - `cart_present=0`: reads come from ROM.
  - CPU writes are dropped.
  - Loader writes always go to RAM.
- 0x800–0x9FF: RAM, read/write for all requesters.
- 0xA00–0xBFF and 0xE00–0xFFF: multicart space. Reads come from RAM; only the loader may write.
- 0xC00–0xDFF: see Configuration.

Arbitration is combinational, with exactly one grant per cycle.
- Base priority is DMA > loader > CPU.
- `wait_cnt` increments in each cycle where `cpu_req=1` and the loader is granted. It clears when the CPU is granted or when `cpu_req=0`. It saturates at `CPU_MAX_WAIT`.
- When `wait_cnt == CPU_MAX_WAIT`, priority becomes DMA > CPU > loader. DMA is never pre-empted, because video timing is fixed.
- A dropped write still consumes its grant and pulses `prot_err` in the grant cycle. RAM and ROM are untouched.
- A loader write is never dropped except in the ROM region.

Read-return pipeline:
- It registers `owner` ∈ {NONE, CPU, DMA} and `src` ∈ {RAM, ROM, FF}.
- In the cycle after a granted read, exactly one of `cpu_rvalid`/`dma_rvalid` is 1.
- The corresponding rdata is muxed from `mem_rdata`, `rom_rdata`, or 0xFF according to `src`.
- A granted write produces no rvalid.

## Timing
- Grant and memory strobes (`mem_ce`, `mem_we`, `mem_addr`, `mem_wdata`, `rom_addr`) are combinational in cycle N.
- rvalid/rdata are valid in cycle N+1, with a latency of 1. The pipeline accepts one read per cycle back-to-back.
- Reset values:
  - All `*_gnt`, `*_rvalid`, `mem_ce`, `mem_we`, and `prot_err` are 0.
  - `cpu_rdata` and `dma_rdata` are 0x00.
  - `wait_cnt` is 0 and `owner` is NONE.
- Reset asserted mid-read: the pending rvalid is suppressed. After deassertion, the first cycle arbitrates fresh.
- Simultaneous requests: exactly one grant per cycle. Ungranted requesters must hold their request; this block does not queue.
- `wait_cnt` saturates and never wraps.

## Configuration
- `STUDIO2_RAM_MIRROR_EN` defined: 0xC00–0xDFF mirrors 0x800–0x9FF for reads and writes (`mem_addr = {3'b100, addr[8:0]}`).
- Not defined: 0xC00–0xDFF is unmapped ROM space. Reads return 0xFF (`src` = FF, `mem_ce` = 0). Writes are dropped and pulse `prot_err`.

## Structure
Package `studio2_pkg` holds:
- `owner_t` and `src_t` enums.
- Region base/limit constants (`ROM_BASE`, `CART_BASE`, `RAM_BASE`, `MCART_LO_BASE`, `MIRROR_BASE`, `MCART_HI_BASE`).
- Typedef `region_t`.

One sub-module, `studio2_addr_decode`, maps (12-bit addr, `cart_present`, requester) to `region_t`, `src_t`, write-permit, and the physical RAM/ROM address. It is instantiated once, on the granted requester's address.

## Test plan
1. DMA and CPU both request reads at 0x900 (RAM holds 0x5A) → `dma_gnt` in cycle N, `dma_rvalid=1`/`dma_rdata=0x5A` in N+1. CPU granted in N+1; `cpu_rdata=0x5A` in N+2.
2. Loader streams writes continuously while CPU holds `cpu_req` (`CPU_MAX_WAIT=3`) → CPU is granted on the 4th cycle, then the loader resumes.
3. CPU writes 0x77 to 0x010 and to 0x500 → `prot_err` pulses twice and `mem_we` stays 0. Reading 0x500 with `cart_present=0` returns `rom_rdata`.
4. Loader writes 0xC3 to 0x400; CPU reads 0x400 with `cart_present=1` → `cpu_rdata=0xC3`.
5. CPU writes 0x33 to 0xC10, then reads 0x810 → with the macro, 0x33. Without the macro, `prot_err` pulses and reading 0xC10 returns 0xFF.
6. Assert `reset` in the cycle after a granted CPU read → `cpu_rvalid` stays 0. All outputs hold their reset values until the first post-reset grant.
